// File: rtl/bp_me_dram_burst_adapter.sv
// Block-to-burst adapter between the L2 memory channel and a narrow-beat DRAM port.
// One transaction in flight: a command is sent as a DRAM address command, then write
// beats go out or read beats come back, and a full-block response echoes the header.
module bp_me_dram_burst_adapter #(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned block_width_p = 512,
  parameter int unsigned beat_width_p  = 64,
  parameter int unsigned hdr_width_p   = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic [hdr_width_p-1:0]   mem_cmd_hdr_i,
  input  logic [paddr_width_p-1:0] mem_cmd_addr_i,
  input  logic                     mem_cmd_w_i,
  input  logic [block_width_p-1:0] mem_cmd_data_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_yumi_o,

  output logic [hdr_width_p-1:0]   mem_resp_hdr_o,
  output logic [block_width_p-1:0] mem_resp_data_o,
  output logic                     mem_resp_v_o,
  input  logic                     mem_resp_ready_i,

  output logic                     dram_cmd_w_o,
  output logic [paddr_width_p-1:0] dram_cmd_addr_o,
  output logic                     dram_cmd_v_o,
  input  logic                     dram_cmd_ready_i,

  output logic [beat_width_p-1:0]  dram_wdata_o,
  output logic                     dram_wdata_v_o,
  input  logic                     dram_wdata_ready_i,

  input  logic [beat_width_p-1:0]  dram_rdata_i,
  input  logic                     dram_rdata_v_i,
  output logic                     dram_rdata_ready_o
);

  localparam int unsigned beats_lp     = block_width_p / beat_width_p;
  localparam int unsigned offset_lp    = $clog2(block_width_p / 8);
  localparam int unsigned cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  if ((block_width_p % beat_width_p) != 0) begin : gen_bad_beat_width
    $error("block_width_p must be a multiple of beat_width_p");
  end

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StResp} state_e;

  state_e                                 state_q, state_d;
  logic [cnt_width_lp-1:0]                cnt_q, cnt_d;
  logic [hdr_width_p-1:0]                 hdr_q, hdr_d;
  logic [paddr_width_p-1:0]               addr_q, addr_d;
  logic                                   w_q, w_d;
  // Beat 0 sits in the least-significant slice of the block.
  logic [beats_lp-1:0][beat_width_p-1:0]  data_q, data_d;
  logic                                   last_beat;

  assign last_beat = (cnt_q == cnt_width_lp'(beats_lp - 1));

  // Next-state and capture logic for the transaction FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    addr_d  = addr_q;
    w_d     = w_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (mem_cmd_v_i) begin
          hdr_d                  = mem_cmd_hdr_i;
          addr_d                 = mem_cmd_addr_i;
          addr_d[offset_lp-1:0]  = '0;
          w_d                    = mem_cmd_w_i;
          // Reads start from a clean block so nothing stale can leak out.
          data_d                 = mem_cmd_w_i ? mem_cmd_data_i : '0;
          cnt_d                  = '0;
          state_d                = StCmd;
        end
      end
      StCmd: begin
        if (dram_cmd_ready_i) begin
          state_d = w_q ? StWdata : StRdata;
        end
      end
      StWdata: begin
        if (dram_wdata_ready_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end
      end
      StRdata: begin
        if (dram_rdata_v_i) begin
          data_d[cnt_q] = dram_rdata_i;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end
      end
      StResp: begin
        if (mem_resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and payload registers; reset abandons any burst in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hdr_q   <= '0;
      addr_q  <= '0;
      w_q     <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      data_q  <= data_d;
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    mem_cmd_yumi_o     = mem_cmd_v_i & (state_q == StIdle);
    dram_cmd_v_o       = (state_q == StCmd);
    dram_wdata_v_o     = (state_q == StWdata);
    dram_rdata_ready_o = (state_q == StRdata);
    mem_resp_v_o       = (state_q == StResp);
  end

  assign dram_cmd_w_o    = w_q;
  assign dram_cmd_addr_o = addr_q;
  assign dram_wdata_o    = data_q[cnt_q];
  assign mem_resp_hdr_o  = hdr_q;
  assign mem_resp_data_o = w_q ? '0 : data_q;

endmodule

// File: tb/tb_bp_me_dram_burst_adapter.sv
// Bench for the DRAM burst adapter: an 8-beat instance driven by a transaction-level
// DRAM/cache model with optional random backpressure, plus a single-beat instance.
module tb_bp_me_dram_burst_adapter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 8-beat instance
  logic [63:0]  mem_cmd_hdr;
  logic [39:0]  mem_cmd_addr;
  logic         mem_cmd_w;
  logic [511:0] mem_cmd_data;
  logic         mem_cmd_v, mem_cmd_yumi;
  logic [63:0]  mem_resp_hdr;
  logic [511:0] mem_resp_data;
  logic         mem_resp_v, mem_resp_ready;
  logic         dram_cmd_w;
  logic [39:0]  dram_cmd_addr;
  logic         dram_cmd_v, dram_cmd_ready;
  logic [63:0]  dram_wdata;
  logic         dram_wdata_v, dram_wdata_ready;
  logic [63:0]  dram_rdata;
  logic         dram_rdata_v, dram_rdata_ready;

  // single-beat instance
  logic [63:0]  b_cmd_hdr;
  logic [39:0]  b_cmd_addr;
  logic         b_cmd_w;
  logic [511:0] b_cmd_data;
  logic         b_cmd_v, b_yumi;
  logic [63:0]  b_resp_hdr;
  logic [511:0] b_resp_data;
  logic         b_resp_v, b_resp_ready;
  logic         b_dcmd_w;
  logic [39:0]  b_dcmd_addr;
  logic         b_dcmd_v, b_dcmd_ready;
  logic [511:0] b_wdata;
  logic         b_wdata_v, b_wdata_ready;
  logic [511:0] b_rdata;
  logic         b_rdata_v, b_rdata_ready;

  logic [63:0]  rbeat [8];
  int n_pass  = 0;
  int n_total = 0;

  bp_me_dram_burst_adapter dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_hdr_i(mem_cmd_hdr), .mem_cmd_addr_i(mem_cmd_addr), .mem_cmd_w_i(mem_cmd_w),
    .mem_cmd_data_i(mem_cmd_data), .mem_cmd_v_i(mem_cmd_v), .mem_cmd_yumi_o(mem_cmd_yumi),
    .mem_resp_hdr_o(mem_resp_hdr), .mem_resp_data_o(mem_resp_data), .mem_resp_v_o(mem_resp_v),
    .mem_resp_ready_i(mem_resp_ready),
    .dram_cmd_w_o(dram_cmd_w), .dram_cmd_addr_o(dram_cmd_addr), .dram_cmd_v_o(dram_cmd_v),
    .dram_cmd_ready_i(dram_cmd_ready),
    .dram_wdata_o(dram_wdata), .dram_wdata_v_o(dram_wdata_v),
    .dram_wdata_ready_i(dram_wdata_ready),
    .dram_rdata_i(dram_rdata), .dram_rdata_v_i(dram_rdata_v),
    .dram_rdata_ready_o(dram_rdata_ready)
  );

  bp_me_dram_burst_adapter #(.beat_width_p(512)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_hdr_i(b_cmd_hdr), .mem_cmd_addr_i(b_cmd_addr), .mem_cmd_w_i(b_cmd_w),
    .mem_cmd_data_i(b_cmd_data), .mem_cmd_v_i(b_cmd_v), .mem_cmd_yumi_o(b_yumi),
    .mem_resp_hdr_o(b_resp_hdr), .mem_resp_data_o(b_resp_data), .mem_resp_v_o(b_resp_v),
    .mem_resp_ready_i(b_resp_ready),
    .dram_cmd_w_o(b_dcmd_w), .dram_cmd_addr_o(b_dcmd_addr), .dram_cmd_v_o(b_dcmd_v),
    .dram_cmd_ready_i(b_dcmd_ready),
    .dram_wdata_o(b_wdata), .dram_wdata_v_o(b_wdata_v), .dram_wdata_ready_i(b_wdata_ready),
    .dram_rdata_i(b_rdata), .dram_rdata_v_i(b_rdata_v), .dram_rdata_ready_o(b_rdata_ready)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One full transaction on the 8-beat instance. bp is the stall percentage applied to
  // every ready/valid the bench controls. abort_beat >= 0 returns once that many read
  // beats have been delivered. Starts and ends just after a rising edge.
  task automatic run_txn(input logic w, input logic [39:0] addr, input logic [511:0] data,
                         input logic [63:0] hdr, input int bp, input int abort_beat,
                         output int cycles);
    int n_cmd = 0, n_wbeat = 0, n_rbeat = 0, n_resp = 0, t = 0;
    bit accepted = 0, cmd_done = 0, hs_cmd;
    logic [511:0] got_w = '0, got_data = '0, exp_r = '0;
    logic [63:0]  got_hdr = '0;
    logic [39:0]  c_addr = '0;
    logic         c_w = 1'b0;
    bit           p_cv = 0, p_wv = 0, p_rv = 0;
    logic [40:0]  p_cmd = '0;
    logic [63:0]  p_wd = '0, p_rh = '0;
    logic [511:0] p_rd = '0;
    for (int k = 0; k < 8; k++) exp_r[k*64 +: 64] = rbeat[k];
    cycles = 0;
    while (n_resp == 0 && t < 300) begin
      #1;
      mem_cmd_hdr      = hdr;
      mem_cmd_addr     = addr;
      mem_cmd_w        = w;
      mem_cmd_data     = data;
      mem_cmd_v        = 1'b1;
      dram_cmd_ready   = ($urandom_range(99) >= bp);
      dram_wdata_ready = ($urandom_range(99) >= bp);
      mem_resp_ready   = ($urandom_range(99) >= bp);
      dram_rdata_v     = cmd_done && !c_w && (n_rbeat < 8) && ($urandom_range(99) >= bp);
      dram_rdata       = dram_rdata_v ? rbeat[n_rbeat] : {$urandom, $urandom};
      #1;
      if (!accepted) check("yumi_idle", mem_cmd_yumi, 1'b1);
      else           check("yumi_busy", mem_cmd_yumi, 1'b0);
      if (p_cv) check("cmd_hold", {dram_cmd_v, dram_cmd_w, dram_cmd_addr}, {1'b1, p_cmd});
      if (p_wv) check("wdata_hold", {dram_wdata_v, dram_wdata}, {1'b1, p_wd});
      if (p_rv) begin
        check("resp_hold", {mem_resp_v, mem_resp_hdr}, {1'b1, p_rh});
        check("resp_data_hold", mem_resp_data, p_rd);
      end
      if (accepted || mem_cmd_yumi) cycles++;
      hs_cmd = dram_cmd_v & dram_cmd_ready;
      p_cv   = dram_cmd_v & !dram_cmd_ready;
      p_cmd  = {dram_cmd_w, dram_cmd_addr};
      p_wv   = dram_wdata_v & !dram_wdata_ready;
      p_wd   = dram_wdata;
      p_rv   = mem_resp_v & !mem_resp_ready;
      p_rh   = mem_resp_hdr;
      p_rd   = mem_resp_data;
      if (hs_cmd) begin
        n_cmd++;
        c_addr   = dram_cmd_addr;
        c_w      = dram_cmd_w;
        cmd_done = 1;
      end
      if (dram_wdata_v & dram_wdata_ready) begin
        if (n_wbeat < 8) got_w[n_wbeat*64 +: 64] = dram_wdata;
        n_wbeat++;
      end
      if (dram_rdata_v & dram_rdata_ready) n_rbeat++;
      if (mem_resp_v & mem_resp_ready) begin
        n_resp++;
        got_hdr  = mem_resp_hdr;
        got_data = mem_resp_data;
      end
      if (mem_cmd_yumi) accepted = 1;
      @(posedge clk);
      if (abort_beat >= 0 && n_rbeat == abort_beat) return;
      t++;
    end
    check("resp_count", n_resp, 1);
    check("cmd_count", n_cmd, 1);
    check("cmd_addr", c_addr, addr & ~40'h3f);
    check("cmd_w", c_w, w);
    check("resp_hdr", got_hdr, hdr);
    if (w) begin
      check("wbeat_count", n_wbeat, 8);
      check("wbeat_data", got_w, data);
      check("wresp_data", got_data, '0);
    end else begin
      check("rbeat_count", n_rbeat, 8);
      check("rresp_data", got_data, exp_r);
    end
  endtask

  // Zero-stall transaction on the single-beat instance, checked cycle by cycle.
  task automatic b_txn(input logic w, input logic [39:0] addr, input logic [511:0] data,
                       input logic [511:0] rdata, input logic [63:0] hdr);
    #1;
    b_cmd_hdr = hdr; b_cmd_addr = addr; b_cmd_w = w; b_cmd_data = data; b_cmd_v = 1'b1;
    b_dcmd_ready = 1'b1; b_wdata_ready = 1'b1; b_resp_ready = 1'b1; b_rdata_v = 1'b0;
    #1 check("b_yumi", b_yumi, 1'b1);
    @(posedge clk);
    #1 b_cmd_v = 1'b0;
    #1 check("b_cmd", {b_dcmd_v, b_dcmd_w, b_dcmd_addr}, {1'b1, w, addr & ~40'h3f});
    @(posedge clk);
    #1 b_rdata_v = !w; b_rdata = rdata;
    #1;
    if (w) begin
      check("b_wbeat_v", b_wdata_v, 1'b1);
      check("b_wbeat", b_wdata, data);
    end else begin
      check("b_rready", b_rdata_ready, 1'b1);
    end
    @(posedge clk);
    #1 b_rdata_v = 1'b0;
    #1 check("b_resp", {b_resp_v, b_resp_hdr}, {1'b1, hdr});
    check("b_resp_data", b_resp_data, w ? 512'b0 : rdata);
    @(posedge clk);
    #1 b_cmd_v = 1'b1;
    #1 check("b_back_idle", {b_resp_v, b_yumi}, 2'b01);
    b_cmd_v = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [511:0] d;
    int cyc;
    reset_n = 1'b0;
    {mem_cmd_hdr, mem_cmd_addr, mem_cmd_w, mem_cmd_data, mem_cmd_v} = '0;
    {mem_resp_ready, dram_cmd_ready, dram_wdata_ready, dram_rdata, dram_rdata_v} = '0;
    {b_cmd_hdr, b_cmd_addr, b_cmd_w, b_cmd_data, b_cmd_v} = '0;
    {b_resp_ready, b_dcmd_ready, b_wdata_ready, b_rdata, b_rdata_v} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valids", {mem_resp_v, dram_cmd_v, dram_wdata_v, dram_rdata_ready}, 4'b0);
    check("rst_regs", {mem_resp_hdr, dram_cmd_addr, dram_cmd_w}, '0);
    check("rst_data", mem_resp_data, '0);
    reset_n = 1'b1;
    @(posedge clk);

    // Directed write: beat k = 0x1111*k, unaligned address.
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = 64'h1111 * k;
    run_txn(1'b1, 40'h80_0000_47, d, 64'hC0DE_0001, 0, -1, cyc);
    check("t1_turnaround", cyc, 11);

    // Directed read: beats A0..A7.
    for (int k = 0; k < 8; k++) rbeat[k] = 64'hA0 + 64'(k);
    run_txn(1'b0, 40'h1000, rand_block(), 64'hC0DE_0002, 0, -1, cyc);
    check("t2_turnaround", cyc, 11);

    // Random traffic under backpressure.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) rbeat[k] = {$urandom, $urandom};
      run_txn(1'($urandom_range(1)), {8'($urandom), 32'($urandom)}, rand_block(),
              {$urandom, $urandom}, 40, -1, cyc);
    end

    // Back-to-back: two writes then two reads, command held valid throughout.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) rbeat[k] = {$urandom, $urandom};
      run_txn(i < 2, {8'($urandom), 32'($urandom)}, rand_block(), 64'(100 + i), 0, -1, cyc);
      check("b2b_turnaround", cyc, 11);
    end

    // Reset in the middle of a read burst.
    for (int k = 0; k < 8; k++) rbeat[k] = {$urandom, $urandom};
    run_txn(1'b0, 40'h2000, '0, 64'hDEAD, 0, 3, cyc);
    #1;
    mem_cmd_v = 1'b0; dram_rdata_v = 1'b0; mem_resp_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valids", {mem_resp_v, dram_cmd_v, dram_wdata_v, dram_rdata_ready}, 4'b0);
    check("mid_rst_data", mem_resp_data, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) rbeat[k] = {$urandom, $urandom};
    run_txn(1'b0, 40'h3040, rand_block(), 64'hBEEF, 0, -1, cyc);
    check("post_rst_turnaround", cyc, 11);

    // Single-beat configuration.
    b_txn(1'b1, 40'h44_0000_0123, rand_block(), '0, 64'h51);
    b_txn(1'b0, 40'h00_0000_7fff, rand_block(), rand_block(), 64'h52);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
